// File: rtl/ct_merge_pkg.sv
// Shared definitions for the ct_merge family: clog2 helper, grant state type and
// reset constants used by ct_merge_wrr and its round-robin picker.
package ct_merge_pkg;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) begin
         res++;
      end
      return res;
   endfunction

   typedef enum logic {
      ST_ARB  = 1'b0,
      ST_LOCK = 1'b1
   } state_e;

   localparam state_e RST_STATE     = ST_ARB;
   localparam int     RST_CUR       = 0;
   localparam logic   RST_STG_VALID = 1'b0;
   localparam logic   RST_OUT_VALID = 1'b0;

endpackage

// File: rtl/ct_rr_pick.sv
// Round-robin picker: the first valid input after cur (wrapping), cur itself last;
// returns cur when no other input is valid. Purely combinational.
module ct_rr_pick #(
   parameter int NI     = 2,
   parameter int NIBITS = 1
) (
   input  logic [NI-1:0]     stg_valid_din_i,
   input  logic [NIBITS-1:0] cur_i,
   output logic [NIBITS-1:0] rr_next_o
);

   // The second loop overrides the first, so any index above cur beats a wrapped one,
   // and within each loop the lowest index wins because it is written last.
   always_comb begin
      rr_next_o = cur_i;
      for (int k = NI - 1; k >= 0; k--) begin
         if (stg_valid_din_i[k] && (NIBITS'(k) < cur_i)) begin
            rr_next_o = NIBITS'(k);
         end
      end
      for (int k = NI - 1; k >= 0; k--) begin
         if (stg_valid_din_i[k] && (NIBITS'(k) > cur_i)) begin
            rr_next_o = NIBITS'(k);
         end
      end
   end

endmodule

// File: rtl/ct_merge_wrr.sv
// ct_merge_wrr: packet-aware weighted round-robin N-to-1 merge with per-input staging.
// Define CT_MERGE_WRR_OUTREG_EN to insert a one-entry register slice before the outputs.
module ct_merge_wrr
   import ct_merge_pkg::*;
#(
   parameter  int NI     = 2,
   parameter  int WIDTH  = 8,
   parameter  int QBITS  = 4,
   localparam int NIBITS = (NI > 1) ? clog2(NI) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NI*WIDTH-1:0]   i_data,
   input  logic [NI-1:0]         i_valid,
   input  logic [NI-1:0]         i_eop,
   output logic [NI-1:0]         o_ready,
   input  logic [NI*QBITS-1:0]   i_quantum,
   output logic [WIDTH-1:0]      o_data,
   output logic                  o_eop,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [NIBITS-1:0]     o_cur_input,
   output logic                  o_locked
);

   logic [WIDTH-1:0]  stg_data_q [NI];
   logic [NI-1:0]     stg_eop_q;
   logic [NI-1:0]     stg_valid_q;
   logic [NI-1:0]     stg_valid_din;
   logic [NI-1:0]     rdy;

   logic [NIBITS-1:0] cur_q, cur_d;
   logic [NIBITS-1:0] rr_next;
   state_e            state_q, state_d;
   logic [QBITS-1:0]  pkt_cnt_q, pkt_cnt_d;

   logic [WIDTH-1:0]  mux_data;
   logic              mux_eop;
   logic              mux_valid;
   logic              cur_din;
   logic [QBITS-1:0]  cur_quant;
   logic [QBITS:0]    eff_quant;
   logic [QBITS:0]    cnt_inc;
   logic              eop_done;
   logic              accept;
   logic              take;

   // Staging readiness and the next-cycle view of every staging valid
   always_comb begin
      for (int i = 0; i < NI; i++) begin
         rdy[i]           = !stg_valid_q[i] || ((cur_q == NIBITS'(i)) && accept);
         stg_valid_din[i] = rdy[i] ? i_valid[i] : stg_valid_q[i];
      end
   end

   assign o_ready = rdy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NI; i++) begin
            stg_valid_q[i] <= RST_STG_VALID;
            stg_eop_q[i]   <= 1'b0;
            stg_data_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (rdy[i]) begin
               stg_valid_q[i] <= i_valid[i];
               stg_eop_q[i]   <= i_eop[i];
               stg_data_q[i]  <= i_data[WIDTH*i +: WIDTH];
            end
         end
      end
   end

   // Select the granted staging entry and its quantum
   always_comb begin
      mux_data  = '0;
      mux_eop   = 1'b0;
      mux_valid = 1'b0;
      cur_din   = 1'b0;
      cur_quant = '0;
      for (int i = 0; i < NI; i++) begin
         if (cur_q == NIBITS'(i)) begin
            mux_data  = stg_data_q[i];
            mux_eop   = stg_eop_q[i];
            mux_valid = stg_valid_q[i];
            cur_din   = stg_valid_din[i];
            cur_quant = i_quantum[QBITS*i +: QBITS];
         end
      end
   end

`ifdef CT_MERGE_WRR_OUTREG_EN
   logic [WIDTH-1:0] slc_data_q;
   logic             slc_eop_q;
   logic             slc_valid_q;

   assign accept = !slc_valid_q || i_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slc_valid_q <= RST_OUT_VALID;
         slc_eop_q   <= 1'b0;
         slc_data_q  <= '0;
      end else if (accept) begin
         slc_valid_q <= mux_valid;
         slc_eop_q   <= mux_eop;
         slc_data_q  <= mux_data;
      end
   end

   assign o_data  = slc_data_q;
   assign o_eop   = slc_eop_q;
   assign o_valid = slc_valid_q;
`else
   assign accept  = mux_valid && i_ready;
   assign o_data  = mux_data;
   assign o_eop   = mux_eop;
   assign o_valid = mux_valid;
`endif

   assign take = accept && mux_valid;

   ct_rr_pick #(
      .NI     (NI),
      .NIBITS (NIBITS)
   ) u_rr_pick (
      .stg_valid_din_i (stg_valid_din),
      .cur_i           (cur_q),
      .rr_next_o       (rr_next)
   );

   // Grant FSM; a zero quantum counts as one packet per grant
   always_comb begin
      cur_d     = cur_q;
      state_d   = state_q;
      pkt_cnt_d = pkt_cnt_q;
      eop_done  = 1'b0;
      eff_quant = (cur_quant == '0) ? (QBITS+1)'(1) : {1'b0, cur_quant};
      cnt_inc   = {1'b0, pkt_cnt_q} + (QBITS+1)'(1);

      case (state_q)
         ST_ARB: begin
            if (!mux_valid) begin
               cur_d     = rr_next;
               pkt_cnt_d = '0;
            end else if (take) begin
               if (mux_eop) begin
                  eop_done = 1'b1;
               end else begin
                  state_d = ST_LOCK;
               end
            end
         end
         ST_LOCK: begin
            if (take && mux_eop) begin
               state_d  = ST_ARB;
               eop_done = 1'b1;
            end
         end
         default: state_d = ST_ARB;
      endcase

      if (eop_done) begin
         if ((cnt_inc >= eff_quant) || !cur_din) begin
            cur_d     = rr_next;
            pkt_cnt_d = '0;
         end else begin
            pkt_cnt_d = cnt_inc[QBITS-1:0];
         end
      end

      if (NI == 1) begin
         cur_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_q     <= NIBITS'(RST_CUR);
         state_q   <= RST_STATE;
         pkt_cnt_q <= '0;
      end else begin
         cur_q     <= cur_d;
         state_q   <= state_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign o_cur_input = cur_q;
   assign o_locked    = (state_q == ST_LOCK);

endmodule

// File: tb/tb_ct_merge_wrr.sv
// Bench for ct_merge_wrr (NI=4): directed lock/reset sequences plus randomized
// packet streams scored against a packet-level weighted round-robin model.
module tb_ct_merge_wrr;

   localparam int NI     = 4;
   localparam int WIDTH  = 8;
   localparam int QBITS  = 4;
   localparam int NIBITS = 2;
   localparam int MEMD   = 512;
`ifdef CT_MERGE_WRR_OUTREG_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 0;
`endif

   logic                clk = 1'b0;
   logic                reset;
   logic [NI*WIDTH-1:0] i_data;
   logic [NI-1:0]       i_valid;
   logic [NI-1:0]       i_eop;
   logic [NI-1:0]       o_ready;
   logic [NI*QBITS-1:0] i_quantum;
   logic [WIDTH-1:0]    o_data;
   logic                o_eop;
   logic                o_valid;
   logic                i_ready;
   logic [NIBITS-1:0]   o_cur_input;
   logic                o_locked;

   int checks = 0;
   int errors = 0;

   logic [WIDTH:0] in_mem [NI][MEMD];
   int             in_wr [NI];
   int             in_rd [NI];
   logic [WIDTH:0] exp_q [$];
   int             src_q [$];

   ct_merge_wrr #(
      .NI    (NI),
      .WIDTH (WIDTH),
      .QBITS (QBITS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_data      (i_data),
      .i_valid     (i_valid),
      .i_eop       (i_eop),
      .o_ready     (o_ready),
      .i_quantum   (i_quantum),
      .o_data      (o_data),
      .o_eop       (o_eop),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_cur_input (o_cur_input),
      .o_locked    (o_locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_valid = '0;
      i_eop   = '0;
      i_data  = '0;
   endtask

   task automatic drive(input int i, input logic v, input logic [WIDTH-1:0] d, input logic e);
      i_valid[i]               = v;
      i_data[i*WIDTH +: WIDTH] = d;
      i_eop[i]                 = e;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   function automatic int next_active(input int c, input logic [NI-1:0] m);
      for (int s = 1; s <= NI; s++) begin
         if (m[(c + s) % NI]) return (c + s) % NI;
      end
      return c;
   endfunction

   function automatic int quant_of(input int c);
      int q;
      q = int'(i_quantum[c*QBITS +: QBITS]);
      return (q == 0) ? 1 : q;
   endfunction

   // Every active input always has a packet waiting, so the grant simply rotates over
   // the active set, each input sending max(1,quantum) whole packets per turn.
   task automatic run_stream(input logic [NI-1:0] mask, input int min_len, input int max_len,
                             input int rdy_mode, input int ncyc, input bit do_rst);
      int             c;
      int             len;
      int             bubbles;
      int             beats;
      bit             seen;
      bit             prev_stall;
      logic [WIDTH:0] beat;
      logic [WIDTH:0] prev_beat;
      logic [NIBITS-1:0] prev_cur;
      logic [NI-1:0]  hs;
      int             src;

      if (do_rst) do_reset();
      for (int i = 0; i < NI; i++) begin
         in_wr[i] = 0;
         in_rd[i] = 0;
      end
      exp_q.delete();
      src_q.delete();

      c = next_active(0, mask);
      while (exp_q.size() < 400) begin
         for (int p = 0; p < quant_of(c); p++) begin
            len = $urandom_range(max_len, min_len);
            for (int b = 0; b < len; b++) begin
               beat = {(b == len - 1), WIDTH'($urandom)};
               if (in_wr[c] < MEMD) begin
                  in_mem[c][in_wr[c]] = beat;
                  in_wr[c]++;
               end
               exp_q.push_back(beat);
               src_q.push_back(c);
            end
         end
         c = next_active(c, mask);
      end

      bubbles    = 0;
      beats      = 0;
      seen       = 1'b0;
      prev_stall = 1'b0;
      prev_beat  = '0;
      prev_cur   = '0;
      for (int n = 0; n < ncyc; n++) begin
         for (int i = 0; i < NI; i++) begin
            if (mask[i] && (in_rd[i] < in_wr[i])) begin
               i_valid[i] = 1'b1;
               {i_eop[i], i_data[i*WIDTH +: WIDTH]} = in_mem[i][in_rd[i]];
            end else begin
               i_valid[i] = 1'b0;
               i_eop[i]   = 1'b0;
            end
         end
         case (rdy_mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ($urandom_range(3, 0) != 0);
            default: i_ready = !(((n >= 20) && (n < 23)) || ((n >= 50) && (n < 53)));
         endcase

         to_neg();
         hs = i_valid & o_ready;
         if (prev_stall) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_beat", 32'({o_eop, o_data}), 32'(prev_beat));
            chk("hold_cur", 32'(o_cur_input), 32'(prev_cur));
         end
         if (o_valid) seen = 1'b1;
         else if (seen && (rdy_mode == 0)) bubbles++;
         if (o_valid && i_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL sb_extra: got beat %0h want none", {o_eop, o_data});
            end
            if (exp_q.size() > 0) begin
               beat = exp_q.pop_front();
               src  = src_q.pop_front();
               chk("sb_beat", 32'({o_eop, o_data}), 32'(beat));
`ifndef CT_MERGE_WRR_OUTREG_EN
               chk("sb_src", 32'(o_cur_input), 32'(src));
`endif
            end
            beats++;
         end
         prev_stall = o_valid && !i_ready;
         prev_beat  = {o_eop, o_data};
         prev_cur   = o_cur_input;
         to_pos();
         for (int i = 0; i < NI; i++) begin
            if (hs[i]) in_rd[i]++;
         end
      end

      checks++;
      assert (beats >= ncyc / 4) else begin
         errors++;
         $error("FAIL progress: got %0d beats want >= %0d", beats, ncyc / 4);
      end
      if (rdy_mode == 0) chk("no_bubble", 32'(bubbles), 32'd0);
      idle_inputs();
      i_ready = 1'b1;
   endtask

   logic [WIDTH-1:0]  rec_data  [12];
   logic              rec_valid [12];
   logic              rec_eop   [12];
   logic              rec_lock  [12];
   logic [NI-1:0]     rec_rdy   [12];
   logic [NIBITS-1:0] rec_cur   [12];

   initial begin
      reset     = 1'b1;
      i_ready   = 1'b1;
      i_quantum = {4'd1, 4'd1, 4'd1, 4'd1};
      idle_inputs();

      // Reset values
      repeat (2) @(posedge clk);
      to_neg();
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_eop", 32'(o_eop), 32'd0);
      chk("rst_data", 32'(o_data), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'hF);
      chk("rst_cur", 32'(o_cur_input), 32'd0);
      chk("rst_locked", 32'(o_locked), 32'd0);
      to_pos();
      reset = 1'b0;

      // Four inputs streaming single-beat packets, quantum 1, no backpressure
      i_quantum = {4'd1, 4'd1, 4'd1, 4'd1};
      run_stream(4'b1111, 1, 1, 0, 120, 1'b1);

      // Quantum {3,1} with back-to-back 2-beat packets on inputs 0 and 1
      i_quantum = {4'd1, 4'd1, 4'd1, 4'd3};
      run_stream(4'b0011, 2, 2, 1, 200, 1'b1);

      // Input 1 arrives while input 0 is in the middle of a 5-beat packet
      i_quantum = {4'd1, 4'd1, 4'd1, 4'd1};
      do_reset();
      for (int n = 0; n < 12; n++) begin
         idle_inputs();
         if (n <= 4) drive(0, 1'b1, WIDTH'(8'hA0 + n), (n == 4));
         if (n == 1) drive(1, 1'b1, 8'hB0, 1'b1);
         to_neg();
         if (n <= 4) chk("lk_rdy0", 32'(o_ready[0]), 32'd1);
         rec_data[n]  = o_data;
         rec_valid[n] = o_valid;
         rec_eop[n]   = o_eop;
         rec_lock[n]  = o_locked;
         rec_rdy[n]   = o_ready;
         rec_cur[n]   = o_cur_input;
         to_pos();
      end
      for (int k = 0; k < 5; k++) begin
         chk("lk_a_valid", 32'(rec_valid[1+k+LAT]), 32'd1);
         chk("lk_a_data", 32'(rec_data[1+k+LAT]), 32'(8'hA0 + k));
         chk("lk_a_eop", 32'(rec_eop[1+k+LAT]), 32'(k == 4));
      end
      chk("lk_lock_c1", 32'(rec_lock[1]), 32'd0);
      for (int k = 2; k <= 5; k++) chk("lk_lock_mid", 32'(rec_lock[k]), 32'd1);
      chk("lk_lock_c6", 32'(rec_lock[6]), 32'd0);
      chk("lk_rdy1_c2", 32'(rec_rdy[2][1]), 32'd0);
      chk("lk_rdy1_c5", 32'(rec_rdy[5][1]), 32'd0);
      chk("lk_cur_c6", 32'(rec_cur[6]), 32'd1);
      chk("lk_b_valid", 32'(rec_valid[6+LAT]), 32'd1);
      chk("lk_b_beat", 32'({rec_eop[6+LAT], rec_data[6+LAT]}), 32'({1'b1, 8'hB0}));
      chk("lk_idle", 32'(rec_valid[8+LAT]), 32'd0);

      // Three-cycle backpressure windows in the middle of multi-beat packets
      run_stream(4'b0101, 3, 5, 2, 100, 1'b1);

      // Reset asserted while beat 2 of a 4-beat packet is presented
      do_reset();
      drive(0, 1'b1, 8'h10, 1'b0);
      to_neg();
      to_pos();
      drive(0, 1'b1, 8'h11, 1'b0);
      drive(2, 1'b1, 8'h20, 1'b1);
      to_neg();
      to_pos();
      idle_inputs();
      reset = 1'b1;
      to_neg();
      chk("rm_valid", 32'(o_valid), 32'd0);
      chk("rm_cur", 32'(o_cur_input), 32'd0);
      chk("rm_ready", 32'(o_ready), 32'hF);
      chk("rm_locked", 32'(o_locked), 32'd0);
      to_pos();
      reset = 1'b0;
      run_stream(4'b0010, 1, 4, 0, 60, 1'b0);

      // Quantum 0 on input 2 must act as 1
      i_quantum = {4'd2, 4'd0, 4'd1, 4'd2};
      run_stream(4'b0111, 1, 3, 1, 200, 1'b1);

      // Fully random quanta, lengths and backpressure
      for (int i = 0; i < NI; i++) i_quantum[i*QBITS +: QBITS] = QBITS'($urandom_range(3, 0));
      run_stream(4'b1111, 1, 4, 1, 300, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ct_merge_wrr.md
# ct_merge_wrr

Weighted round-robin, packet-aware N-to-1 merge for streaming valid/ready/eop channels. It is the successor to the existing fair merge: same per-input staging and packet lock, plus a programmable per-input quantum (packets per grant), observable grant state and an optional output register slice. It sits wherever several packet sources share one downstream sink, such as crossbar output ports and DMA return paths.

## Interface
Parameters:
- NI, 2: number of input channels, ≥1.
- WIDTH, 8: data beat width, ≥1.
- QBITS, 4: width of each per-input quantum field.
- NIBITS, derived as max(1, clog2(NI)); not overridable.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_data  in  NI*WIDTH  input beats; channel i occupies [WIDTH*i +: WIDTH].
- i_valid  in  NI  per-input valid.
- i_eop  in  NI  per-input end-of-packet.
- o_ready  out  NI  per-input ready (combinational).
- i_quantum  in  NI*QBITS  packets per grant for each input; quasi-static; value 0 behaves as 1.
- o_data  out  WIDTH  merged beat.
- o_eop  out  1  merged end-of-packet.
- o_valid  out  1  merged valid.
- i_ready  in  1  downstream ready.
- o_cur_input  out  NIBITS  index of the input currently holding the grant.
- o_locked  out  1  high while the grant is locked mid-packet.

## Operation
- Staging: each input has one register holding {data, eop, valid}.
  - o_ready[i] = !stg_valid[i] || (cur==i && accept).
  - When o_ready[i] is high, the staging register loads i_valid/i_data/i_eop. Otherwise it recirculates.
- accept = o_valid && i_ready without the output slice (see Configuration for the slice case).
- Grant state: cur (NIBITS), state ∈ {ARB, LOCK}, pkt_cnt (QBITS).
- Round-robin pick (rr_next): scans stg_valid_din starting at cur+1 and wrapping. cur itself has lowest priority. If no input is valid, the result is cur.
- ARB state:
  - If the cur staging register is empty, cur ← rr_next and pkt_cnt ← 0.
  - On an accepted beat with eop=0, state → LOCK.
- LOCK state: cur is frozen. Other inputs stall with their staging held. An accepted eop beat → ARB.
- Accepted eop beat (in either state):
  - If pkt_cnt+1 ≥ max(1, quantum[cur]), or cur's next staging entry is not valid: cur ← rr_next and pkt_cnt ← 0.
  - Otherwise cur holds and pkt_cnt increments.
- Single-beat packets (eop on the first beat) never enter LOCK.
- NI=1: cur is tied to 0. Arbitration is trivial, but lock and quantum counting still apply.
- Changing i_quantum mid-grant takes effect at the next eop comparison.

## Timing
- Reset values: o_valid=0, o_eop=0, o_data=0, o_ready=all 1s, o_cur_input=0, o_locked=0, pkt_cnt=0, state=ARB, all staging valids 0.
- Latency: a beat accepted at edge N is presented on o_valid in cycle N+1. Add one cycle with the output slice enabled.
- Throughput: 1 beat/clk sustained.
  - Switching grant on an eop costs no bubble when another input is staged, because the pick uses stg_valid_din.
- While i_ready=0 with o_valid=1: the output is held stable and cur, state and pkt_cnt do not change.
- Reset asserted mid-packet: all staged beats are discarded and the grant returns to input 0 in ARB.

## Configuration
- Macro CT_MERGE_WRR_OUTREG_EN.
- Defined: a one-entry register slice sits between the staging mux and the outputs.
  - o_data, o_eop and o_valid are registered.
  - accept = slice empty or i_ready.
  - Latency is +1 cycle. Throughput is still 1/clk.
- Undefined: the outputs are combinational from the staging mux.

## Structure
- Shared package ct_merge_pkg holds:
  - the clog2 function;
  - the typedef of state {ST_ARB, ST_LOCK};
  - the reset constants.
- Sub-module ct_rr_pick(NI, NIBITS): takes stg_valid_din and cur, returns rr_next. It is purely combinational.

## Test plan
- NI=4, quantum all 1, all inputs streaming 1-beat packets with i_ready=1 → grant order 0,1,2,3,0…; one beat per clk with no bubble.
- NI=2, quantum={3,1}, both inputs with back-to-back 2-beat packets → 3 packets from input 0 (6 beats), then 1 from input 1 (2 beats), repeating.
- Input 1 raises valid while input 0 is mid-packet (5 beats) → o_locked=1 for beats 1–4, o_ready[1] low after staging fills, and input 1's first beat appears the cycle after input 0's eop.
- i_ready held low for 3 cycles mid-packet → o_data/o_eop stable and o_cur_input unchanged; no beat lost or duplicated (scoreboard compare).
- Reset asserted during beat 2 of a 4-beat packet → next cycle o_valid=0, o_cur_input=0, o_ready=4'b1111; a fresh packet afterwards passes intact.
- Quantum=0 on input 2 with NI=3 → behaves identically to quantum=1.
